// File: rtl/bsg_tag_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bsg_tag_serial_decoder
// Purpose  : Reassembles bsg_tag serial packets (start, node, dnr, len, payload)
//            into registered fields with one-cycle v_o / err_o strobes.
// Option   : define BSG_TAG_DECODER_PARITY_EN to expect a trailing parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_tag_serial_decoder #(
  parameter int els_p               = 4,
  parameter int max_payload_width_p = 8,
  localparam int lg_els_lp          = $clog2(els_p),
  localparam int lg_len_lp          = $clog2(max_payload_width_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           tag_en_i,
  input  logic                           tag_data_i,
  output logic                           v_o,
  output logic [lg_els_lp-1:0]           node_id_o,
  output logic                           data_not_reset_o,
  output logic [lg_len_lp-1:0]           len_o,
  output logic [max_payload_width_p-1:0] data_o,
  output logic                           err_o
);

  localparam int cnt_w_lp = (lg_els_lp > lg_len_lp) ? lg_els_lp : lg_len_lp;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NODE,
    S_DNR,
    S_LEN,
    S_PAYLOAD,
`ifdef BSG_TAG_DECODER_PARITY_EN
    S_PARITY,
`endif
    S_EMIT
  } state_e;

`ifdef BSG_TAG_DECODER_PARITY_EN
  localparam state_e S_AFTER_PAY = S_PARITY;
`else
  localparam state_e S_AFTER_PAY = S_EMIT;
`endif

  state_e                         state_q;
  logic [cnt_w_lp-1:0]            cnt_q;
  logic [lg_els_lp-1:0]           node_q;
  logic                           dnr_q;
  logic [lg_len_lp-1:0]           len_q;
  logic [max_payload_width_p-1:0] data_q;
  logic                           ovf_q;
  logic [lg_len_lp-1:0]           len_full_d;
  logic                           bad_node_d;
  logic                           par_fail_d;

  // Length as it will read once the bit now on the wire (its MSB) is taken.
  always_comb begin
    len_full_d                = len_q;
    len_full_d[lg_len_lp-1]   = tag_data_i;
  end

  assign bad_node_d = ({1'b0, node_q} >= (lg_els_lp + 1)'(els_p));

`ifdef BSG_TAG_DECODER_PARITY_EN
  logic par_q;
  logic par_fail_q;
  assign par_fail_d = par_fail_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      par_q      <= 1'b0;
      par_fail_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      par_q      <= 1'b0;
      par_fail_q <= 1'b0;
    end else if (tag_en_i && (state_q != S_EMIT)) begin
      if (state_q == S_PARITY) par_fail_q <= par_q ^ tag_data_i;
      else                     par_q      <= par_q ^ tag_data_i;
    end
  end
`else
  assign par_fail_d = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      node_q           <= '0;
      dnr_q            <= 1'b0;
      len_q            <= '0;
      data_q           <= '0;
      ovf_q            <= 1'b0;
      v_o              <= 1'b0;
      err_o            <= 1'b0;
      node_id_o        <= '0;
      data_not_reset_o <= 1'b0;
      len_o            <= '0;
      data_o           <= '0;
    end else begin
      v_o   <= 1'b0;
      err_o <= 1'b0;
      case (state_q)
        S_IDLE: if (tag_en_i && tag_data_i) begin
          cnt_q   <= '0;
          node_q  <= '0;
          dnr_q   <= 1'b0;
          len_q   <= '0;
          data_q  <= '0;
          ovf_q   <= 1'b0;
          state_q <= S_NODE;
        end
        S_NODE: if (tag_en_i) begin
          for (int i = 0; i < lg_els_lp; i++)
            if (cnt_q == cnt_w_lp'(i)) node_q[i] <= tag_data_i;
          if (cnt_q == cnt_w_lp'(lg_els_lp - 1)) begin
            cnt_q   <= '0;
            state_q <= S_DNR;
          end else begin
            cnt_q <= cnt_q + cnt_w_lp'(1);
          end
        end
        S_DNR: if (tag_en_i) begin
          dnr_q   <= tag_data_i;
          state_q <= S_LEN;
        end
        S_LEN: if (tag_en_i) begin
          for (int i = 0; i < lg_len_lp; i++)
            if (cnt_q == cnt_w_lp'(i)) len_q[i] <= tag_data_i;
          if (cnt_q == cnt_w_lp'(lg_len_lp - 1)) begin
            cnt_q   <= '0;
            state_q <= (len_full_d == '0) ? S_AFTER_PAY : S_PAYLOAD;
          end else begin
            cnt_q <= cnt_q + cnt_w_lp'(1);
          end
        end
        S_PAYLOAD: if (tag_en_i) begin
          // Bits beyond the held width are swallowed but flag the packet bad.
          if (cnt_q >= cnt_w_lp'(max_payload_width_p)) ovf_q <= 1'b1;
          for (int i = 0; i < max_payload_width_p; i++)
            if (cnt_q == cnt_w_lp'(i)) data_q[i] <= tag_data_i;
          if ((cnt_q + cnt_w_lp'(1)) == cnt_w_lp'(len_q)) begin
            cnt_q   <= '0;
            state_q <= S_AFTER_PAY;
          end else begin
            cnt_q <= cnt_q + cnt_w_lp'(1);
          end
        end
`ifdef BSG_TAG_DECODER_PARITY_EN
        S_PARITY: if (tag_en_i) state_q <= S_EMIT;
`endif
        S_EMIT: begin
          v_o              <= ~(ovf_q | bad_node_d | par_fail_d);
          err_o            <=  (ovf_q | bad_node_d | par_fail_d);
          node_id_o        <= node_q;
          data_not_reset_o <= dnr_q;
          len_o            <= len_q;
          data_o           <= data_q;
          state_q          <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_tag_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_tag_serial_decoder
// Purpose  : Directed self-checking bench for bsg_tag_serial_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_tag_serial_decoder;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       tag_en_i = 1'b0;
  logic       tag_data_i = 1'b0;
  logic       v_o;
  logic [1:0] node_id_o;
  logic       data_not_reset_o;
  logic [3:0] len_o;
  logic [7:0] data_o;
  logic       err_o;
  logic [16:0] obs;

  int vectors = 0;
  int miscompares = 0;

  assign obs = {v_o, err_o, node_id_o, data_not_reset_o, len_o, data_o};

  always #5 clk_i = ~clk_i;

  bsg_tag_serial_decoder #(.els_p(4), .max_payload_width_p(8)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .tag_en_i         (tag_en_i),
    .tag_data_i       (tag_data_i),
    .v_o              (v_o),
    .node_id_o        (node_id_o),
    .data_not_reset_o (data_not_reset_o),
    .len_o            (len_o),
    .data_o           (data_o),
    .err_o            (err_o)
  );

  task automatic drive(input logic en, input logic d);
    @(negedge clk_i);
    tag_en_i   = en;
    tag_data_i = d;
  endtask

  // Drives a whole packet; stall_n disabled cycles are inserted before payload bit stall_at.
  task automatic send_packet(input logic [1:0] node, input logic dnr, input logic [3:0] len,
                             input logic [15:0] pay, input int stall_at, input int stall_n,
                             input logic flip);
    logic par;
    par = (^node) ^ dnr ^ (^len);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, node[i]);
    drive(1'b1, dnr);
    for (int i = 0; i < 4; i++) drive(1'b1, len[i]);
    for (int k = 0; k < int'(len); k++) begin
      if (k == stall_at) repeat (stall_n) drive(1'b0, 1'b1);
      drive(1'b1, pay[k]);
      par = par ^ pay[k];
    end
`ifdef BSG_TAG_DECODER_PARITY_EN
    drive(1'b1, par ^ flip);
`else
    if (flip) $display("note: parity flip ignored, parity not compiled in");
`endif
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk_i);
    vectors++;
    if (obs !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", obs, 17'h0);
    end
    reset_i    = 1'b0;
    tag_en_i   = 1'b1;
    tag_data_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      vectors++;
      if (obs !== 17'h0) begin
        miscompares++;
        $display("FAIL idle_zeros[%0d]: got %h expected %h", c, obs, 17'h0);
      end
    end
    tag_en_i = 1'b0;
  endtask

  task automatic test_basic(input int stall_n, input string nm);
    send_packet(2'd2, 1'b1, 4'd5, 16'b10110, 2, stall_n, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    vectors++;
    if ({v_o, err_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_early: v/err got %b expected 00", nm, {v_o, err_o});
    end
    @(negedge clk_i);
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'd2, 1'b1, 4'd5, 8'h16}) begin
      miscompares++;
      $display("FAIL %s_strobe: got %h expected %h", nm, obs, {1'b1, 1'b0, 2'd2, 1'b1, 4'd5, 8'h16});
    end
    @(negedge clk_i);
    vectors++;
    if (obs !== {1'b0, 1'b0, 2'd2, 1'b1, 4'd5, 8'h16}) begin
      miscompares++;
      $display("FAIL %s_hold: got %h expected %h", nm, obs, {1'b0, 1'b0, 2'd2, 1'b1, 4'd5, 8'h16});
    end
  endtask

  task automatic test_len_zero();
    send_packet(2'd1, 1'b0, 4'd0, 16'h0, -1, 0, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    vectors++;
    if ({v_o, err_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL len0_early: v/err got %b expected 00", {v_o, err_o});
    end
    @(negedge clk_i);
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'd1, 1'b0, 4'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL len0_strobe: got %h expected %h", obs, {1'b1, 1'b0, 2'd1, 1'b0, 4'd0, 8'h00});
    end
  endtask

  task automatic test_overflow();
    send_packet(2'd1, 1'b1, 4'd10, 16'b11_0101_1100, -1, 0, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if ({v_o, err_o, len_o} !== {1'b0, 1'b1, 4'd10}) begin
      miscompares++;
      $display("FAIL ovf_strobe: v/err/len got %h expected %h", {v_o, err_o, len_o}, {1'b0, 1'b1, 4'd10});
    end
    // Full-width payload right after the dropped packet.
    send_packet(2'd3, 1'b1, 4'd8, 16'h00A5, -1, 0, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'd3, 1'b1, 4'd8, 8'hA5}) begin
      miscompares++;
      $display("FAIL post_ovf: got %h expected %h", obs, {1'b1, 1'b0, 2'd3, 1'b1, 4'd8, 8'hA5});
    end
  endtask

  task automatic test_reset_abort();
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    @(negedge clk_i); reset_i = 1'b1; tag_en_i = 1'b1; tag_data_i = 1'b1;
    @(negedge clk_i); reset_i = 1'b0; tag_en_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      vectors++;
      if (obs !== 17'h0) begin
        miscompares++;
        $display("FAIL abort_quiet[%0d]: got %h expected %h", c, obs, 17'h0);
      end
    end
    send_packet(2'd3, 1'b1, 4'd3, 16'b101, -1, 0, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'd3, 1'b1, 4'd3, 8'h05}) begin
      miscompares++;
      $display("FAIL post_abort: got %h expected %h", obs, {1'b1, 1'b0, 2'd3, 1'b1, 4'd3, 8'h05});
    end
  endtask

  task automatic test_back_to_back();
    // Next start bit presented in the slot right after EMIT.
    send_packet(2'd0, 1'b1, 4'd2, 16'b11, -1, 0, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    send_packet(2'd2, 1'b0, 4'd1, 16'b1, -1, 0, 1'b0);
    @(negedge clk_i); tag_en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'd2, 1'b0, 4'd1, 8'h01}) begin
      miscompares++;
      $display("FAIL back_to_back: got %h expected %h", obs, {1'b1, 1'b0, 2'd2, 1'b0, 4'd1, 8'h01});
    end
  endtask

`ifdef BSG_TAG_DECODER_PARITY_EN
  task automatic test_parity();
    send_packet(2'd2, 1'b1, 4'd5, 16'b10110, -1, 0, 1'b1);
    @(negedge clk_i); tag_en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if ({v_o, err_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL parity_flip: v/err got %b expected 01", {v_o, err_o});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "stall");
    test_len_zero();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
`ifdef BSG_TAG_DECODER_PARITY_EN
    test_parity();
`endif
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
